matrix_tx_formatter: RTL
========================

Name: matrix_tx_formatter

Overview:
- Output-side counterpart to the UART input subsystem: on a start pulse it reads an M x N matrix of 32-bit unsigned elements from matrix memory.
- Each element is converted to decimal ASCII with leading zeros suppressed.
- The resulting byte stream goes to a byte-level UART transmitter using a start/busy handshake.
- Used by the top FSM to display stored, generated and computed matrices.

Parameters:
- ADDR_W, 9, matrix memory address width.
- DATA_W, 32, element width (unsigned); maximum printable value 4294967295 (10 digits).
- MAX_DIM, 5, largest legal M or N.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  address of element (0,0); row-major layout
- dim_m  in  3  row count, legal range 1..MAX_DIM
- dim_n  in  3  column count, legal range 1..MAX_DIM
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  base_addr + r*dim_n + c, truncated mod 2^ADDR_W
- rd_data  in  DATA_W  memory data, valid exactly 1 cycle after rd_en
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit pulse
- tx_busy  in  1  transmitter busy
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err_dim  out  1  one-cycle pulse, coincident with done, when dims are illegal

Behaviour:
- Reset: state IDLE; rd_en, tx_start, busy, done and err_dim are 0; tx_data, rd_addr and internal counters are 0.
- Inputs: dim_m, dim_n and base_addr are latched when start is accepted. Later input changes are ignored. start is ignored while busy.
- Dimension check: if dim_m or dim_n is 0 or greater than MAX_DIM, the next cycle pulses done and err_dim together, no bytes are sent, and the block returns to IDLE.
- Output format: elements in a row are separated by one space (0x20). Every row, including the last, ends with CR (0x0D) then LF (0x0A). No trailing space.
- States:
  - IDLE: on start, latch inputs and set busy.
  - RD_REQ: rd_en=1 for one cycle.
  - RD_WAIT: latch rd_data into the working value.
  - CONV: decade index k runs 9 down to 0 using a constant 10^k table. While value >= 10^k, subtract 10^k and increment the digit; at most one subtraction per cycle.
    - When the digit is final, emit ASCII 0x30+digit if digit != 0, or a nonzero digit has already been emitted for this element, or k == 0.
    - Otherwise drop the digit and move to the next k.
  - SEP: after the element, send a space (c < N-1) or CR then LF (c == N-1). Then advance c, or reset c and advance r.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Byte send sub-sequence, used for every byte:
  - SEND waits until tx_busy == 0, then drives tx_data and tx_start=1 for exactly one cycle.
  - GUARD lasts one cycle, ignoring tx_busy, to cover busy-rise latency.
  - WAIT holds until tx_busy == 0, then resumes the caller.
  - tx_data holds its value from the tx_start cycle until the next byte is loaded.
  - At most one tx_start per byte; tx_start is never asserted while tx_busy is 1.
- Digit arithmetic: the working value is DATA_W bits. Subtraction occurs only when value >= 10^k, so there is no underflow. A value of 0 prints "0".
- Completion: after the LF of row M-1, go to DONE. Total bytes = sum over elements of digit count + M*(N-1) spaces + 2M.
- Reset mid-operation: immediate return to IDLE; any partially sent frame is abandoned; tx_start deasserts asynchronously.
- Simultaneous events: a start arriving in the same cycle as done is ignored. A new start is accepted from the cycle after done.

Test Plan:
- 2x3 matrix [1 2 3; 4 5 6] at base 0, tx_busy held 0 by an ideal model -> bytes "1 2 3\r\n4 5 6\r\n" (14 bytes); done pulse once; rd_addr sequence 0..5.
- 1x1 value 0 -> bytes "0\r\n"; 1x2 values 4294967295 and 10 -> "4294967295 10\r\n".
- Real uart_tx model (115200 baud at 25 MHz), 3x3 matrix with values 7 -> every byte sent exactly once, in order; tx_start never asserted while tx_busy is 1.
- dim_m=0 with dim_n=3, then dim_m=6 with dim_n=1 -> each gives done and err_dim in the same cycle; tx_start and rd_en stay 0.
- base_addr=510, 1x4 matrix -> rd_addr sequence 510, 511, 0, 1 (wrap-around).
- rst_n asserted during the second byte of a 5x5 print -> outputs return to reset values at once; a subsequent start prints the full frame correctly.

Source files
------------

// File: rtl/matrix_tx_formatter.sv
// Streams an M x N matrix from memory as decimal ASCII rows ("a b c\r\n") to a byte UART.
// Each byte waits for tx_busy low, pulses tx_start once, then waits out the transmitter.
module matrix_tx_formatter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        dim_m,
  input  logic [2:0]        dim_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              err_dim
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CONV, S_SEP, S_SEND, S_GUARD, S_WAIT, S_DONE
  } state_t;

  localparam logic [2:0] MAX_D = 3'(MAX_DIM);

  state_t             state_q, state_nxt, ret_q, ret_nxt;
  logic [DATA_W-1:0]  val_q, val_nxt, p10;
  logic [3:0]         k_q, k_nxt, digit_q, digit_nxt;
  logic               nz_q, nz_nxt, lf_q, lf_nxt, err_q, err_nxt;
  logic [2:0]         r_q, r_nxt, c_q, c_nxt, m_q, m_nxt, n_q, n_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [7:0]         tx_data_q, tx_data_nxt;
  logic               dims_ok;

  function automatic logic [DATA_W-1:0] pow10(input logic [3:0] k);
    case (k)
      4'd1:    pow10 = DATA_W'(64'd10);
      4'd2:    pow10 = DATA_W'(64'd100);
      4'd3:    pow10 = DATA_W'(64'd1000);
      4'd4:    pow10 = DATA_W'(64'd10000);
      4'd5:    pow10 = DATA_W'(64'd100000);
      4'd6:    pow10 = DATA_W'(64'd1000000);
      4'd7:    pow10 = DATA_W'(64'd10000000);
      4'd8:    pow10 = DATA_W'(64'd100000000);
      4'd9:    pow10 = DATA_W'(64'd1000000000);
      default: pow10 = DATA_W'(64'd1);
    endcase
  endfunction

  assign p10      = pow10(k_q);
  assign dims_ok  = (dim_m != 3'd0) && (dim_m <= MAX_D) && (dim_n != 3'd0) && (dim_n <= MAX_D);
  assign rd_addr  = addr_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      val_q     <= '0;
      k_q       <= '0;
      digit_q   <= '0;
      nz_q      <= 1'b0;
      lf_q      <= 1'b0;
      err_q     <= 1'b0;
      r_q       <= '0;
      c_q       <= '0;
      m_q       <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_nxt;
      ret_q     <= ret_nxt;
      val_q     <= val_nxt;
      k_q       <= k_nxt;
      digit_q   <= digit_nxt;
      nz_q      <= nz_nxt;
      lf_q      <= lf_nxt;
      err_q     <= err_nxt;
      r_q       <= r_nxt;
      c_q       <= c_nxt;
      m_q       <= m_nxt;
      n_q       <= n_nxt;
      addr_q    <= addr_nxt;
      tx_data_q <= tx_data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    ret_nxt     = ret_q;
    val_nxt     = val_q;
    k_nxt       = k_q;
    digit_nxt   = digit_q;
    nz_nxt      = nz_q;
    lf_nxt      = lf_q;
    err_nxt     = err_q;
    r_nxt       = r_q;
    c_nxt       = c_q;
    m_nxt       = m_q;
    n_nxt       = n_q;
    addr_nxt    = addr_q;
    tx_data_nxt = tx_data_q;
    rd_en       = 1'b0;
    tx_start    = 1'b0;
    done        = 1'b0;
    err_dim     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_nxt     = dim_m;
          n_nxt     = dim_n;
          addr_nxt  = base_addr;
          r_nxt     = '0;
          c_nxt     = '0;
          lf_nxt    = 1'b0;
          err_nxt   = !dims_ok;
          state_nxt = dims_ok ? S_RD_REQ : S_DONE;
        end
      end
      S_RD_REQ: begin
        rd_en     = 1'b1;
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Row-major storage makes every element address a simple increment.
        val_nxt   = rd_data;
        k_nxt     = 4'd9;
        digit_nxt = '0;
        nz_nxt    = 1'b0;
        addr_nxt  = addr_q + ADDR_W'(1);
        state_nxt = S_CONV;
      end
      S_CONV: begin
        if (val_q >= p10) begin
          val_nxt   = val_q - p10;
          digit_nxt = digit_q + 4'd1;
        end else if ((digit_q != 4'd0) || nz_q || (k_q == 4'd0)) begin
          tx_data_nxt = 8'h30 + {4'h0, digit_q};
          nz_nxt      = 1'b1;
          digit_nxt   = '0;
          state_nxt   = S_SEND;
          if (k_q == 4'd0) begin
            ret_nxt = S_SEP;
          end else begin
            ret_nxt = S_CONV;
            k_nxt   = k_q - 4'd1;
          end
        end else begin
          k_nxt = k_q - 4'd1;
        end
      end
      S_SEP: begin
        state_nxt = S_SEND;
        if (lf_q) begin
          tx_data_nxt = 8'h0A;
          lf_nxt      = 1'b0;
          c_nxt       = '0;
          r_nxt       = r_q + 3'd1;
          ret_nxt     = (r_q == m_q - 3'd1) ? S_DONE : S_RD_REQ;
        end else if (c_q == n_q - 3'd1) begin
          tx_data_nxt = 8'h0D;
          lf_nxt      = 1'b1;
          ret_nxt     = S_SEP;
        end else begin
          tx_data_nxt = 8'h20;
          c_nxt       = c_q + 3'd1;
          ret_nxt     = S_RD_REQ;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = S_GUARD;
        end
      end
      // One blind cycle: the transmitter may raise busy a cycle after tx_start.
      S_GUARD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (!tx_busy) state_nxt = ret_q;
      end
      S_DONE: begin
        done      = 1'b1;
        err_dim   = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
